// File: rtl/ad9228_fifo_drain.sv
// ad9228_fifo_drain: round-robin drain of the AD9228 per-channel sample FIFOs into a 32-bit valid/ready stream.
// Optional build macro AD9228_DRAIN_HEADER_EN adds a timestamped header word ahead of each channel visit.
module ad9228_fifo_drain #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 12,
  parameter int BURST_LEN    = 16,
  localparam int AW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [AW-1:0]           fifo_addr,
  output logic [NUM_CHANNELS-1:0] fifo_rd_en,
  input  logic                    fifo_not_empty,
  input  logic                    fifo_full,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic [31:0]             m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy
);

  // state  | meaning
  // SCAN   | idle / walking channels one per cycle looking for data
  // RD0    | read strobe for the low (earlier) sample
  // CAP0   | capture low sample; decide pair or partial word
  // RD1    | read strobe for the high sample
  // CAP1   | capture high sample, build the word
  // EMIT   | word presented, held until accepted
  // ADV    | end of visit: clear sample count, move to next channel
  // HDR    | header word presented (header build only)
  typedef enum logic [2:0] {
    S_SCAN, S_RD0, S_CAP0, S_RD1, S_CAP1, S_EMIT, S_ADV, S_HDR
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           ch_ptr_q, ch_next;
  logic [1:0]              ch_tag;
  logic [8:0]              cnt_q, cnt_inc;
  logic [11:0]             lo_q;
  logic [31:0]             m_data_q;
  logic                    m_last_q;
  logic [2:0]              seq_q;
  logic [NUM_CHANNELS-1:0] ovf_q;
  logic                    go_rd1;
  logic [8:0]              burst_cnt;
`ifdef AD9228_DRAIN_HEADER_EN
  logic [23:0]             ts_q;
`endif

  assign burst_cnt = 9'(BURST_LEN);
  assign cnt_inc   = cnt_q + 9'd1;
  assign go_rd1    = fifo_not_empty && (cnt_inc < burst_cnt);
  assign ch_next   = (ch_ptr_q == AW'(NUM_CHANNELS - 1)) ? '0 : ch_ptr_q + 1'b1;

  always_comb begin
    ch_tag = '0;
    ch_tag[AW-1:0] = ch_ptr_q;
  end

  assign fifo_addr = ch_ptr_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign m_valid   = (state_q == S_EMIT) || (state_q == S_HDR);
  assign busy      = (state_q != S_SCAN);

  always_comb begin
    fifo_rd_en = '0;
    if (state_q == S_RD0 || state_q == S_RD1) fifo_rd_en[ch_ptr_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SCAN: begin
        if (enable && fifo_not_empty) begin
`ifdef AD9228_DRAIN_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_RD0;
`endif
        end
      end
`ifdef AD9228_DRAIN_HEADER_EN
      S_HDR:  if (m_ready) state_d = S_RD0;
`endif
      S_RD0:  state_d = S_CAP0;
      S_CAP0: state_d = go_rd1 ? S_RD1 : S_EMIT;
      S_RD1:  state_d = S_CAP1;
      S_CAP1: state_d = S_EMIT;
      S_EMIT: begin
        // m_last already marks the end of the visit, so it overrides a late-arriving sample
        if (m_ready) begin
          if (m_last_q || !enable || !fifo_not_empty) state_d = S_ADV;
          else                                        state_d = S_RD0;
        end
      end
      S_ADV:  state_d = S_SCAN;
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SCAN;
      ch_ptr_q <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      seq_q    <= '0;
      ovf_q    <= '0;
`ifdef AD9228_DRAIN_HEADER_EN
      ts_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (fifo_full && ch_ptr_q == AW'(c))
          ovf_q[c] <= 1'b1;
        else if (state_q == S_EMIT && m_ready && ch_ptr_q == AW'(c))
          ovf_q[c] <= 1'b0;
      end
      case (state_q)
        S_SCAN: begin
          if (enable && !fifo_not_empty) ch_ptr_q <= ch_next;
`ifdef AD9228_DRAIN_HEADER_EN
          if (enable && fifo_not_empty) begin
            m_data_q <= {1'b1, ch_tag, 5'd0, ts_q};
            m_last_q <= 1'b0;
          end
`endif
        end
        S_CAP0: begin
          lo_q  <= fifo_dout;
          cnt_q <= cnt_inc;
          if (!go_rd1) begin
            m_data_q <= {1'b0, ch_tag, ovf_q[ch_ptr_q], 1'b1, seq_q, 12'h000, fifo_dout};
            m_last_q <= 1'b1;
          end
        end
        S_CAP1: begin
          cnt_q    <= cnt_inc;
          m_data_q <= {1'b0, ch_tag, ovf_q[ch_ptr_q], 1'b0, seq_q, fifo_dout, lo_q};
          m_last_q <= (cnt_inc == burst_cnt) || !fifo_not_empty;
        end
        S_EMIT: if (m_ready) seq_q <= seq_q + 3'd1;
        S_ADV: begin
          cnt_q    <= '0;
          ch_ptr_q <= ch_next;
        end
        default: ;
      endcase
`ifdef AD9228_DRAIN_HEADER_EN
      ts_q <= ts_q + 24'd1;
`endif
    end
  end

endmodule

// File: tb/tb_ad9228_fifo_drain.sv
// Bench for ad9228_fifo_drain: behavioural FIFO array, queue-based expected-word model, per-cycle compare.
module tb_ad9228_fifo_drain;
  localparam int NCH   = 4;
  localparam int BL    = 16;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, enable, m_ready;
  logic        fifo_not_empty, fifo_full;
  logic [1:0]  fifo_addr;
  logic [3:0]  fifo_rd_en;
  logic [11:0] fifo_dout = '0;
  logic [31:0] m_data;
  logic        m_valid, m_last, busy;

  int checks = 0;
  int failures = 0;

  logic [11:0] mem [NCH][DEPTH];
  int          rdp [NCH];
  int          cnt_f [NCH];
  logic [32:0] expq [$];
  bit          sb_on = 1'b1;
  int          ready_mode = 1;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
`ifdef AD9228_DRAIN_HEADER_EN
  logic [23:0] hdr_ts = '0;
`endif

  always #5 clk = ~clk;

  ad9228_fifo_drain #(.NUM_CHANNELS(NCH), .DATA_WIDTH(12), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_addr(fifo_addr), .fifo_rd_en(fifo_rd_en),
    .fifo_not_empty(fifo_not_empty), .fifo_full(fifo_full), .fifo_dout(fifo_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  assign fifo_not_empty = (cnt_f[fifo_addr] != 0);
  assign fifo_full      = (cnt_f[fifo_addr] == DEPTH);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO array: a strobe seen mid-cycle pops, data is on fifo_dout for the following cycle
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (fifo_rd_en[c]) begin
        check("read_nonempty", (cnt_f[c] > 0) ? 1 : 0, 1);
        if (cnt_f[c] > 0) begin
          fifo_dout = mem[c][rdp[c]];
          rdp[c]++;
          cnt_f[c]--;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = ($urandom_range(0, 3) != 0);
      1:       m_ready = 1'b1;
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (m_valid) check("no_read_in_emit", fifo_rd_en, 0);
      if (prev_stall) begin
        check("stall_valid_hold", m_valid, 1);
        check("stall_data_hold", m_data, prev_data);
      end
      if (m_valid && m_ready && sb_on) begin
`ifdef AD9228_DRAIN_HEADER_EN
        if (m_data[31]) begin
          if (expq.size() != 0) check("hdr_chan", m_data[30:29], expq[0][30:29]);
          check("hdr_ts_mono", (m_data[23:0] >= hdr_ts) ? 1 : 0, 1);
          check("hdr_last", m_last, 0);
          hdr_ts = m_data[23:0];
        end else
`endif
        begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got %h, expected no word", m_data);
          end else begin
            e = expq.pop_front();
            check("word", {m_last, m_data}, e);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Expected stream from static FIFO contents: channels visited round robin from 0,
  // each visit takes min(remaining, BL) samples two per word; a channel loaded to
  // DEPTH reports overflow in the first word of its first visit.
  task automatic build_model();
    int rem [NCH];
    int pos [NCH];
    bit ovf [NCH];
    int total = 0;
    int seq = 0;
    int c = 0;
    for (int i = 0; i < NCH; i++) begin
      rem[i] = cnt_f[i];
      pos[i] = 0;
      ovf[i] = (cnt_f[i] == DEPTH);
      total += cnt_f[i];
    end
    while (total > 0) begin
      if (rem[c] > 0) begin
        int k;
        k = (rem[c] < BL) ? rem[c] : BL;
        for (int i = 0; i < k; i += 2) begin
          logic [11:0] lo, hi;
          bit part, last;
          lo   = mem[c][pos[c] + i];
          part = (i + 1 >= k);
          hi   = part ? 12'h000 : mem[c][pos[c] + i + 1];
          last = (i + 2 >= k);
          expq.push_back({last, 1'b0, 2'(c), ovf[c], part, 3'(seq), hi, lo});
          ovf[c] = 1'b0;
          seq++;
        end
        pos[c] += k;
        rem[c] -= k;
        total  -= k;
      end
      c = (c + 1) % NCH;
    end
  endtask

  task automatic begin_round();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", {m_valid, m_last, busy, fifo_rd_en, fifo_addr, m_data}, 0);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      cnt_f[c] = 0;
      rdp[c] = 0;
    end
    expq.delete();
`ifdef AD9228_DRAIN_HEADER_EN
    hdr_ts = '0;
`endif
  endtask

  task automatic load(input int c, input int n, input bit rnd, input int base);
    for (int i = 0; i < n; i++) mem[c][i] = rnd ? 12'($urandom) : 12'(base + i);
    cnt_f[c] = n;
    rdp[c] = 0;
  endtask

  task automatic release_round();
    rst = 1'b0;
    enable = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (expq.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d words still expected, required 0", name, expq.size());
    end
    repeat (12) @(negedge clk);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, seen;
    rst = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      cnt_f[c] = 0;
      rdp[c] = 0;
    end

    // single pair on ch0
    begin_round();
    load(0, 2, 1'b0, 1);
    build_model();
    check("t1_model_n", expq.size(), 1);
    check("t1_model_word", expq[0], {1'b1, 32'h00002001});
    ready_mode = 1;
    release_round();
    wait_drain("t1");

    // odd count on ch2: pair then partial
    begin_round();
    load(2, 3, 1'b0, 'hA);
    build_model();
    check("t2_model_w0", expq[0], {1'b0, 32'h4000B00A});
    check("t2_model_w1", expq[1], {1'b1, 32'h4900000C});
    release_round();
    wait_drain("t2");

    // 40 samples on ch1: bursts of 16, 16, 8
    begin_round();
    load(1, 40, 1'b1, 0);
    build_model();
    check("t3_model_n", expq.size(), 20);
    check("t3_model_last8", {expq[6][32], expq[7][32], expq[19][32]}, 3'b011);
    ready_mode = 0;
    release_round();
    wait_drain("t3");

    // long back-pressure on the first word
    begin_round();
    load(0, 6, 1'b1, 0);
    build_model();
    ready_mode = 2;
    release_round();
    t = 0;
    while (!m_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t4_valid_seen", m_valid, 1);
    repeat (20) @(negedge clk);
    ready_mode = 0;
    wait_drain("t4");

    // ch3 loaded to full: overflow reported once
    begin_round();
    load(3, DEPTH, 1'b1, 0);
    build_model();
    check("t5_model_ovf", {expq[0][30:29], expq[0][28], expq[1][28]}, 4'b1110);
    release_round();
    wait_drain("t5");

    // enable dropped during the first read: one word, then park
    begin_round();
    load(1, 6, 1'b0, 'h111);
    expq.push_back({1'b0, 32'h20112111});
    ready_mode = 1;
    release_round();
    t = 0;
    while (fifo_rd_en == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    wait_drain("endrop");
    check("endrop_addr", fifo_addr, 2);
    check("endrop_left", cnt_f[1], 4);

    // randomized contents and back-pressure
    for (int r = 0; r < 6; r++) begin
      begin_round();
      for (int c = 0; c < NCH; c++)
        load(c, ($urandom_range(0, 9) == 0) ? DEPTH : $urandom_range(0, 40), 1'b1, 0);
      build_model();
      ready_mode = 0;
      release_round();
      wait_drain("rand");
    end

    // reset asserted during the second read strobe
    begin_round();
    load(0, 4, 1'b0, 5);
    sb_on = 1'b0;
    ready_mode = 1;
    release_round();
    seen = 0;
    t = 0;
    while (seen < 2 && t < 200) begin
      @(negedge clk);
      if (fifo_rd_en != 0) seen++;
      t++;
    end
    check("t6_rd1_reached", seen, 2);
    rst = 1'b1;
    @(posedge clk);
    #1 check("t6_rst_outputs", {m_valid, m_last, busy, fifo_rd_en, fifo_addr, m_data}, 0);
    sb_on = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
